// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60 defaults, 800x600@60 alternative)
// and the frame-total helpers used by the timing generator.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // 800x600@60 uses positive sync polarity and needs CW >= 11 (H_TOTAL = 1056).
    localparam int SVGA_H_ACTIVE = 800;
    localparam int SVGA_H_FP     = 40;
    localparam int SVGA_H_SYNC   = 128;
    localparam int SVGA_H_BP     = 88;
    localparam int SVGA_V_ACTIVE = 600;
    localparam int SVGA_V_FP     = 1;
    localparam int SVGA_V_SYNC   = 4;
    localparam int SVGA_V_BP     = 23;

    function automatic int h_total(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video bus between the timing generator (master) and the pixel path (slave).
// No valid/ready: every field is qualified by the generator's pix_en tick, and
// the slave returns colour for the position it saw PIPE_DLY ticks earlier.
interface vga_timing_gen_if #(
    parameter int CW      = 10,
    parameter int COLOR_W = 8
);
    logic [CW-1:0]      hcount;
    logic [CW-1:0]      vcount;
    logic               active;
    logic               line_start;
    logic               frame_start;
    logic [COLOR_W-1:0] pixel_r;
    logic [COLOR_W-1:0] pixel_g;
    logic [COLOR_W-1:0] pixel_b;
    logic [COLOR_W-1:0] VGA_R;
    logic [COLOR_W-1:0] VGA_G;
    logic [COLOR_W-1:0] VGA_B;
    logic               hsync;
    logic               vsync;
    logic               de;

    modport master (
        output hcount, vcount, active, line_start, frame_start,
        output VGA_R, VGA_G, VGA_B, hsync, vsync, de,
        input  pixel_r, pixel_g, pixel_b
    );

    modport slave (
        input  hcount, vcount, active, line_start, frame_start,
        input  VGA_R, VGA_G, VGA_B, hsync, vsync, de,
        output pixel_r, pixel_g, pixel_b
    );
endinterface

// File: rtl/vga_delay_line.sv
// Enabled shift register with async clear; DEPTH=0 is a straight wire.
module vga_delay_line #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    if (DEPTH == 0) begin : g_bypass
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, rst, en};
        assign dout = din;
    end else begin : g_pipe
        logic [WIDTH-1:0] stage [DEPTH];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
            end else if (en) begin
                stage[0] <= din;
                for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
        end

        assign dout = stage[DEPTH-1];
    end
endmodule

// File: rtl/vga_timing_gen.sv
// Programmable VGA timing generator: tick-enabled H/V counters, a sync/de delay
// line matching upstream pixel latency, and registered blanked colour output.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 10,
    parameter int COLOR_W  = 8,
    parameter int PIPE_DLY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_en,
    vga_timing_gen_if.master vif
);
    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_TOTAL > (1 << CW)) begin : g_h_total_err
        $error("vga_timing_gen: H_TOTAL does not fit in CW bits");
    end
    if (V_TOTAL > (1 << CW)) begin : g_v_total_err
        $error("vga_timing_gen: V_TOTAL does not fit in CW bits");
    end

    // Inclusive bounds so a segment ending exactly at 2^CW never wraps to zero.
    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_LAST = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] V_ACT_LAST = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] HS_FIRST   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_LAST    = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_LAST    = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [CW-1:0]      hcount;
    logic [CW-1:0]      vcount;
    logic               line_start_q;
    logic               frame_start_q;
    logic               hs_raw;
    logic               vs_raw;
    logic               de_raw;
    logic [2:0]         dly_in;
    logic [2:0]         dly_out;
    logic               hs_d;
    logic               vs_d;
    logic               de_d;
    logic               hsync_q;
    logic               vsync_q;
    logic               de_q;
    logic [COLOR_W-1:0] r_q;
    logic [COLOR_W-1:0] g_q;
    logic [COLOR_W-1:0] b_q;

    assign de_raw = (hcount <= H_ACT_LAST) && (vcount <= V_ACT_LAST);
    assign hs_raw = (hcount >= HS_FIRST) && (hcount <= HS_LAST);
    assign vs_raw = (vcount >= VS_FIRST) && (vcount <= VS_LAST);
    assign dly_in = {hs_raw, vs_raw, de_raw};
    assign {hs_d, vs_d, de_d} = dly_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount        <= '0;
            vcount        <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            if (pix_en) begin
                if (hcount == H_LAST) begin
                    hcount       <= '0;
                    line_start_q <= 1'b1;
                    if (vcount == V_LAST) begin
                        vcount        <= '0;
                        frame_start_q <= 1'b1;
                    end else begin
                        vcount <= vcount + 1'b1;
                    end
                end else begin
                    hcount <= hcount + 1'b1;
                end
            end
        end
    end

    vga_delay_line #(
        .WIDTH (3),
        .DEPTH (PIPE_DLY)
    ) u_dly (
        .clk  (clk),
        .rst  (rst),
        .en   (pix_en),
        .din  (dly_in),
        .dout (dly_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_q <= ~HS_POL;
            vsync_q <= ~VS_POL;
            de_q    <= 1'b0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
        end else if (pix_en) begin
            hsync_q <= hs_d ? HS_POL : ~HS_POL;
            vsync_q <= vs_d ? VS_POL : ~VS_POL;
            de_q    <= de_d;
            r_q     <= de_d ? vif.pixel_r : '0;
            g_q     <= de_d ? vif.pixel_g : '0;
            b_q     <= de_d ? vif.pixel_b : '0;
        end
    end

    assign vif.hcount      = hcount;
    assign vif.vcount      = vcount;
    assign vif.active      = de_raw;
    assign vif.line_start  = line_start_q;
    assign vif.frame_start = frame_start_q;
    assign vif.hsync       = hsync_q;
    assign vif.vsync       = vsync_q;
    assign vif.de          = de_q;
    assign vif.VGA_R       = r_q;
    assign vif.VGA_G       = g_q;
    assign vif.VGA_B       = b_q;
endmodule
